register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
//   Parametrised multi-port register file; next generation of the single-write/dual-read CPU register file.
//   Adds configurable width/depth/read-port count, a second write port, optional hardwired-zero register 0,
//   optional write-to-read bypass and a per-register busy scoreboard for the pipelined core's hazard unit.
//   Sits between decode (reads, issue) and writeback (two retire lanes).
// PARAMETERS
//   WIDTH     32  data width in bits
//   DEPTH     32  number of registers; address width AW = $clog2(DEPTH)
//   NREAD     2   number of read ports (1..4)
//   ZERO_REG  1   1: reg 0 reads 0, ignores writes, never busy
//   BYPASS    1   1: read of a register being written this cycle returns the new data
// PORTS
//   clk        in   1            clock; all state updates on rising edge
//   rst        in   1            asynchronous, active-low reset
//   ra         in   NREAD*AW     read addresses, port i at [i*AW +: AW]
//   rd         out  NREAD*WIDTH  read data, port i at [i*WIDTH +: WIDTH]
//   rbusy      out  NREAD        busy bit of the register addressed by ra[i]
//   wa0/wa1    in   AW           write addresses, lanes 0/1
//   wd0/wd1    in   WIDTH        write data, lanes 0/1
//   we0/we1    in   1            write enables, lanes 0/1
//   iss_valid  in   1            issue: mark register iss_addr busy (pending result)
//   iss_addr   in   AW           destination register of issued instruction
//   any_busy   out  1            OR of all busy bits
// BEHAVIOUR
//   - Reset (rst=0): all registers = 0, all busy bits = 0, immediately and asynchronously, mid-cycle included;
//     so rd = 0, rbusy = 0, any_busy = 0 while rst low. Writes/issues ignored while rst low.
//   - Reads: combinational, zero-latency; rd[i] = reg[ra[i]].
//   - Writes: registered; reg[waN] <= wdN on rising edge when weN=1. Visible to reads after that edge.
//   - Both lanes write same address same cycle: lane 1 wins (younger instruction).
//   - BYPASS=1: if weN=1 and waN==ra[i] this cycle, rd[i] = wdN (lane 1 priority); BYPASS=0: old value.
//   - ZERO_REG=1: ra[i]==0 -> rd[i]=0, rbusy[i]=0 regardless of bypass; writes/issue to 0 dropped.
//   - Out-of-range address (>= DEPTH, non-power-of-2 DEPTH): reads return 0, writes and issues dropped.
//   - Scoreboard, per register, on rising edge:
//       set   when iss_valid && iss_addr==r
//       clear when (we0 && wa0==r) || (we1 && wa1==r)
//       set and clear same cycle, same r -> set wins (new producer issued; old result retires)
//   - rbusy[i] reflects the registered busy bit; with BYPASS=1 a clear this cycle also forces
//     rbusy[i]=0 combinationally (result available via bypass); issue this cycle does not affect rbusy.
//   - Write to a non-busy register is legal: data updates, busy stays 0.
//   - No internal FSM beyond per-register busy flag (IDLE <-> BUSY); no stall outputs; hazard unit decides.
// TESTING
//   1 rst low 60 ns then high; read all addrs on every port -> all rd=0, rbusy=0, any_busy=0.
//   2 we0=1 wa0=5 wd0=56, edge; ra0=5 -> rd0=56; we0=1 wa0=0 wd0=9 -> ra1=0 reads 0 (ZERO_REG=1).
//   3 we0 wa0=4 wd0=26 and we1 wa1=4 wd1=77 same edge -> rd=77; same cycle ra0=4 pre-edge -> 77 (BYPASS=1),
//     rebuild with BYPASS=0 -> pre-edge read returns old value 0.
//   4 iss_valid iss_addr=7, edge -> rbusy=1 on ra=7, any_busy=1; we1 wa1=7 wd1=3 -> rbusy=0 combinationally,
//     after edge busy clear, rd=3; issue+write to 7 same edge -> busy remains 1.
//   5 Write regs 1..3 and issue 8, then assert rst low between edges -> rd=0, any_busy=0 before next edge.
//   6 Sweep NREAD=1/4, WIDTH=8/64, DEPTH=16/24: random writes vs reference array model, addrs >= DEPTH read 0.

Source files
------------

// File: rtl/register_file_mp.sv
`default_nettype none
// register_file_mp: multi-port register file with two write lanes, optional write-to-read
// bypass, optional hardwired-zero register 0 and a per-register busy scoreboard.
module register_file_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  output logic [NREAD-1:0]       rbusy,
  input  logic [AW-1:0]          wa0,
  input  logic [AW-1:0]          wa1,
  input  logic [WIDTH-1:0]       wd0,
  input  logic [WIDTH-1:0]       wd1,
  input  logic                   we0,
  input  logic                   we1,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_addr,
  output logic                   any_busy
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  // An address is live only if it maps to a real register that is not the hardwired zero.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] w_clr;
  logic [DEPTH-1:0] w_set;
  logic             w_we0;
  logic             w_we1;
  logic             w_iss;

  assign w_we0 = we0 && addr_ok(wa0);
  assign w_we1 = we1 && addr_ok(wa1);
  assign w_iss = iss_valid && addr_ok(iss_addr);

  // Lane 1 is the younger instruction, so its write is applied last.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      regs_d[r] = regs_q[r];
      w_set[r]  = w_iss && (iss_addr == AW'(r));
      w_clr[r]  = (w_we0 && (wa0 == AW'(r))) || (w_we1 && (wa1 == AW'(r)));
      if (w_we0 && (wa0 == AW'(r))) regs_d[r] = wd0;
      if (w_we1 && (wa1 == AW'(r))) regs_d[r] = wd1;
      busy_d[r] = w_set[r] || (busy_q[r] && !w_clr[r]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= regs_d[r];
      busy_q <= busy_d;
    end
  end

  assign any_busy = |busy_q;

  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [AW-1:0]    w_a;
    logic [WIDTH-1:0] w_d;
    logic             w_b;

    assign w_a = ra[i*AW +: AW];

    // Bypass is gated by rst so reads stay zero while reset is held.
    always_comb begin
      w_d = '0;
      w_b = 1'b0;
      if (rst && addr_ok(w_a)) begin
        w_d = regs_q[w_a];
        w_b = busy_q[w_a];
        if (BYPASS != 0) begin
          if (w_we1 && (wa1 == w_a))      w_d = wd1;
          else if (w_we0 && (wa0 == w_a)) w_d = wd0;
          if (w_clr[w_a]) w_b = 1'b0;
        end
      end
    end

    assign rd[i*WIDTH +: WIDTH] = w_d;
    assign rbusy[i]             = w_b;
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// tb_register_file_mp: directed and random stimulus against a bench-side array model of the register file.
module tb_register_file_mp;

  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stimulus shared by the BYPASS=1 (a) and BYPASS=0 (b) instances.
  logic [2*AW-1:0] ra = '0;
  logic [AW-1:0]   wa0 = '0, wa1 = '0, iss_addr = '0;
  logic [31:0]     wd0 = '0, wd1 = '0;
  logic            we0 = 1'b0, we1 = 1'b0, iss_valid = 1'b0;
  logic [63:0]     rd_a, rd_b;
  logic [1:0]      rb_a, rb_b;
  logic            ab_a, ab_b;

  // Sweep instance: NREAD=4, WIDTH=8, DEPTH=24, no zero register.
  logic [19:0] c_ra = '0;
  logic [4:0]  c_wa0 = '0, c_wa1 = '0, c_ia = '0;
  logic [7:0]  c_wd0 = '0, c_wd1 = '0;
  logic        c_we0 = 1'b0, c_we1 = 1'b0, c_iv = 1'b0;
  logic [31:0] c_rd;
  logic [3:0]  c_rb;
  logic        c_ab;

  register_file_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_a), .rbusy(rb_a),
    .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1), .we0(we0), .we1(we1),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .any_busy(ab_a));

  register_file_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_b), .rbusy(rb_b),
    .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1), .we0(we0), .we1(we1),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .any_busy(ab_b));

  register_file_mp #(.WIDTH(8), .DEPTH(24), .NREAD(4), .ZERO_REG(0), .BYPASS(1)) u_c (
    .clk(clk), .rst(rst), .ra(c_ra), .rd(c_rd), .rbusy(c_rb),
    .wa0(c_wa0), .wa1(c_wa1), .wd0(c_wd0), .wd1(c_wd1), .we0(c_we0), .we1(c_we1),
    .iss_valid(c_iv), .iss_addr(c_ia), .any_busy(c_ab));

  // Reference model: plain arrays of contents and busy flags.
  logic [31:0] m_reg  [32];
  bit          m_busy [32];
  logic [7:0]  mc_reg [32];
  bit          mc_busy[32];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[r] = '0; m_busy[r] = 0; mc_reg[r] = '0; mc_busy[r] = 0;
      end
    end else begin
      if (we0 && wa0 != 0) begin m_reg[wa0] = wd0; m_busy[wa0] = 0; end
      if (we1 && wa1 != 0) begin m_reg[wa1] = wd1; m_busy[wa1] = 0; end
      if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1;
      if (c_we0 && c_wa0 < 24) begin mc_reg[c_wa0] = c_wd0; mc_busy[c_wa0] = 0; end
      if (c_we1 && c_wa1 < 24) begin mc_reg[c_wa1] = c_wd1; mc_busy[c_wa1] = 0; end
      if (c_iv && c_ia < 24) mc_busy[c_ia] = 1;
    end
  end

  function automatic logic [31:0] exp_m(input logic [4:0] a, input bit byp);
    if (!rst || a == 0) return '0;
    if (byp && we1 && wa1 == a) return wd1;
    if (byp && we0 && wa0 == a) return wd0;
    return m_reg[a];
  endfunction

  function automatic logic exp_mb(input logic [4:0] a, input bit byp);
    bit clr;
    clr = (we0 && wa0 == a) || (we1 && wa1 == a);
    if (!rst || a == 0) return 1'b0;
    return m_busy[a] && !(byp && clr);
  endfunction

  function automatic logic [7:0] exp_c(input logic [4:0] a);
    if (!rst || a >= 24) return '0;
    if (c_we1 && c_wa1 == a) return c_wd1;
    if (c_we0 && c_wa0 == a) return c_wd0;
    return mc_reg[a];
  endfunction

  function automatic logic exp_cb(input logic [4:0] a);
    bit clr;
    clr = (c_we0 && c_wa0 == a) || (c_we1 && c_wa1 == a);
    if (!rst || a >= 24) return 1'b0;
    return mc_busy[a] && !clr;
  endfunction

  function automatic logic exp_any(input bit main_inst);
    logic o;
    o = 1'b0;
    for (int r = 0; r < 32; r++) o = o | (main_inst ? m_busy[r] : mc_busy[r]);
    return rst && o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("a_rd",    64'(rd_a[i*32 +: 32]), 64'(exp_m(ra[i*AW +: AW], 1)));
      chk("a_rbusy", 64'(rb_a[i]),          64'(exp_mb(ra[i*AW +: AW], 1)));
      chk("b_rd",    64'(rd_b[i*32 +: 32]), 64'(exp_m(ra[i*AW +: AW], 0)));
      chk("b_rbusy", 64'(rb_b[i]),          64'(exp_mb(ra[i*AW +: AW], 0)));
    end
    for (int i = 0; i < 4; i++) begin
      chk("c_rd",    64'(c_rd[i*8 +: 8]), 64'(exp_c(c_ra[i*5 +: 5])));
      chk("c_rbusy", 64'(c_rb[i]),        64'(exp_cb(c_ra[i*5 +: 5])));
    end
    chk("a_any_busy", 64'(ab_a), 64'(exp_any(1)));
    chk("b_any_busy", 64'(ab_b), 64'(exp_any(1)));
    chk("c_any_busy", 64'(c_ab), 64'(exp_any(0)));
  end

  task automatic step();
    @(posedge clk);
    #1;
    we0 = 1'b0; we1 = 1'b0; iss_valid = 1'b0;
  endtask

  initial begin
    // Reset held for 60 ns while sweeping read addresses.
    for (int k = 0; k < 6; k++) begin
      ra = {5'(2*k+1), 5'(2*k)};
      c_ra = {5'(k+18), 5'(k+12), 5'(k+6), 5'(k)};
      #10;
    end
    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      ra = {5'(2*k+1), 5'(2*k)};
      c_ra = {5'(k+16), 5'(k+8), 5'(k+4), 5'(k)};
    end
    #1;
    chk("lit_reset_rd", rd_a, 64'd0);
    chk("lit_reset_busy", 64'({ab_a, rb_a}), 64'd0);

    // Simple write, then zero-register write.
    step(); we0 = 1; wa0 = 5; wd0 = 56; ra = {5'd0, 5'd5};
    #1 chk("lit_bypass_w5", 64'(rd_a[31:0]), 64'd56);
    chk("lit_nobypass_w5", 64'(rd_b[31:0]), 64'd0);
    step(); we0 = 1; wa0 = 0; wd0 = 9; ra = {5'd0, 5'd5};
    #1 chk("lit_read5", 64'(rd_a[31:0]), 64'd56);
    chk("lit_zero_reg", 64'(rd_a[63:32]), 64'd0);

    // Dual write to the same address: lane 1 wins.
    step(); we0 = 1; wa0 = 4; wd0 = 26; we1 = 1; wa1 = 4; wd1 = 77; ra = {5'd0, 5'd4};
    #1 chk("lit_bypass_lane1", 64'(rd_a[31:0]), 64'd77);
    chk("lit_nobypass_old", 64'(rd_b[31:0]), 64'd0);
    step(); ra = {5'd0, 5'd4};
    #1 chk("lit_lane1_wins_a", 64'(rd_a[31:0]), 64'd77);
    chk("lit_lane1_wins_b", 64'(rd_b[31:0]), 64'd77);

    // Scoreboard set, combinational clear, and set-beats-clear.
    step(); iss_valid = 1; iss_addr = 7;
    step(); ra = {5'd0, 5'd7};
    #1 chk("lit_busy_set", 64'({ab_a, rb_a[0]}), 64'b11);
    step(); we1 = 1; wa1 = 7; wd1 = 3; ra = {5'd0, 5'd7};
    #1 chk("lit_busy_fwd_clear", 64'(rb_a[0]), 64'd0);
    chk("lit_busy_nobypass", 64'(rb_b[0]), 64'd1);
    chk("lit_bypass_rd7", 64'(rd_a[31:0]), 64'd3);
    step(); ra = {5'd0, 5'd7};
    #1 chk("lit_busy_cleared", 64'({ab_a, rb_a[0]}), 64'b00);
    chk("lit_rd7", 64'(rd_a[31:0]), 64'd3);
    step(); iss_valid = 1; iss_addr = 7; we0 = 1; wa0 = 7; wd0 = 11;
    step(); ra = {5'd0, 5'd7};
    #1 chk("lit_set_wins", 64'({ab_a, rb_a[0]}), 64'b11);
    chk("lit_rd7_new", 64'(rd_a[31:0]), 64'd11);

    // Mid-cycle asynchronous reset.
    step(); we0 = 1; wa0 = 1; wd0 = 32'h11; we1 = 1; wa1 = 2; wd1 = 32'h22;
    step(); we0 = 1; wa0 = 3; wd0 = 32'h33; iss_valid = 1; iss_addr = 8;
    step(); ra = {5'd2, 5'd1};
    #1 chk("lit_pre_reset", rd_a, 64'h00000022_00000011);
    chk("lit_pre_reset_busy", 64'(ab_a), 64'd1);
    rst = 1'b0;
    #1 chk("lit_async_rd", rd_a, 64'd0);
    chk("lit_async_busy", 64'({ab_a, rb_a}), 64'd0);
    step(); ra = {5'd8, 5'd3};
    step();
    rst = 1'b1;

    // Random traffic on all instances, including addresses beyond DEPTH on the sweep instance.
    for (int k = 0; k < 400; k++) begin
      step();
      we0 = 1'($urandom); we1 = 1'($urandom); iss_valid = 1'($urandom_range(0, 3) == 0);
      wa0 = 5'($urandom); wa1 = 5'($urandom); iss_addr = 5'($urandom);
      wd0 = $urandom; wd1 = $urandom;
      ra = (k % 3 == 0) ? {wa1, wa0} : 10'($urandom);
      c_we0 = 1'($urandom); c_we1 = 1'($urandom); c_iv = 1'($urandom_range(0, 3) == 0);
      c_wa0 = 5'($urandom); c_wa1 = 5'($urandom); c_ia = 5'($urandom);
      c_wd0 = 8'($urandom); c_wd1 = 8'($urandom);
      c_ra = (k % 3 == 0) ? {c_ia, c_wa1, c_wa0, c_wa1} : 20'($urandom);
    end
    step();
    c_we0 = 1'b0; c_we1 = 1'b0; c_iv = 1'b0;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
